// File: rtl/mon_sopc_onchip_ram_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM.
// The master side drives the request; the slave side returns read data and the stall.
interface mon_sopc_onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/mon_sopc_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM: two slave ports on one clock sharing one array,
// pipelined reads (latency 1 or 2), byte-lane writes, s1 priority on write collisions.
module mon_sopc_onchip_ram_dp #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 13,
  parameter int    DEPTH        = 5000,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "mon_sopc_onchip_ram_dp.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      reset_req,
  mon_sopc_onchip_ram_dp_if.slave   s1,
  mon_sopc_onchip_ram_dp_if.slave   s2
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DEPTH < 1 || DEPTH > (1 << ADDR_W) ||
      (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_cfg_err
    $error("mon_sopc_onchip_ram_dp: bad DATA_W/DEPTH/READ_LATENCY (init %s)", INIT_FILE);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 0 is s1, port 1 is s2
  logic [ADDR_W-1:0] addr     [2];
  logic [IDX_W-1:0]  idx      [2];
  logic [BE_W-1:0]   be       [2];
  logic [DATA_W-1:0] wd       [2];
  logic              rd_req   [2];
  logic              wr_req   [2];
  logic              in_range [2];
  logic              rd_acc   [2];
  logic              wr_acc   [2];
  logic [DATA_W-1:0] rdata_out [2];
  logic              vld_out   [2];
  logic              stall;

  assign stall = ~clken | reset_req | reset;

  assign addr[0]   = s1.address;
  assign addr[1]   = s2.address;
  assign be[0]     = s1.byteenable;
  assign be[1]     = s2.byteenable;
  assign wd[0]     = s1.writedata;
  assign wd[1]     = s2.writedata;
  assign rd_req[0] = s1.read;
  assign rd_req[1] = s2.read;
  assign wr_req[0] = s1.write;
  assign wr_req[1] = s2.write;

  assign s1.waitrequest   = stall;
  assign s2.waitrequest   = stall;
  assign s1.readdata      = rdata_out[0];
  assign s2.readdata      = rdata_out[1];
  assign s1.readdatavalid = vld_out[0];
  assign s2.readdatavalid = vld_out[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]      = addr[p][IDX_W-1:0];
      in_range[p] = ({1'b0, addr[p]} < DEPTH_V);
      wr_acc[p]   = wr_req[p] & ~stall;
      // A write on the same port in the same cycle swallows the read
      rd_acc[p]   = rd_req[p] & ~wr_req[p] & ~stall;
    end
  end

  // Write commit: s2 lanes first so s1 overrides any lane both ports enable
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_acc[p] && in_range[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[p][b]) mem[idx[p]][8*b +: 8] <= wd[p][8*b +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_p0;
    logic              vld_p0;

    assign rd_word = in_range[p] ? mem[idx[p]] : '0;

    // Stage p0: array read at the accepting edge (sees pre-write contents)
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p0 <= 1'b0;
      end else if (clken) begin
        vld_p0 <= rd_acc[p];
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_p0 <= '0;
        end else if (rd_acc[p]) begin
          rdata_p0 <= rd_word;
        end
      end

      assign rdata_out[p] = rdata_p0;
      assign vld_out[p]   = vld_p0;
    end else begin : g_lat2
      logic [DATA_W-1:0] rdata_p1;
      logic              vld_p1;

      always_ff @(posedge clk) begin
        if (rd_acc[p]) rdata_p0 <= rd_word;
      end

      // Stage p1: output register, loads only on valid so readdata holds between beats
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1   <= 1'b0;
          rdata_p1 <= '0;
        end else if (clken) begin
          vld_p1 <= vld_p0;
          if (vld_p0) rdata_p1 <= rdata_p0;
        end
      end

      assign rdata_out[p] = rdata_p1;
      assign vld_out[p]   = vld_p1;
    end
  end

endmodule
